// File: rtl/player_input_ctrl_pkg.sv
// Shared definitions for the player-input controller: button bit positions,
// selection FSM states and the default hand size.
package player_input_ctrl_pkg;

    localparam int NUM_CARDS_DEFAULT = 9;
    localparam int NUM_BTNS          = 5;

    localparam int BTN_CENTER = 0;
    localparam int BTN_TOP    = 1;
    localparam int BTN_BOTTOM = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_RIGHT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OFFER = 2'd2
    } sel_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, stability counter, debounced level and a
// one-cycle pulse on each debounced rising edge.
// Macro PLAYER_INPUT_DEBOUNCE_BYPASS_EN removes the counter so the debounced
// level follows the synchronized level directly (fast simulation builds).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse
);

    logic sync_q1;
    logic sync_q2;
    logic level_q;

    // Two-stage synchronizer bringing the asynchronous pin into the clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

`ifdef PLAYER_INPUT_DEBOUNCE_BYPASS_EN

    assign level = sync_q2;

    // Without filtering, the rise pulse comes straight from the synchronized level
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= sync_q2;
            pulse   <= sync_q2 & ~level_q;
        end
    end

`else

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] count;
    logic          level_prev;

    // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            level_q <= 1'b0;
        end else if (sync_q2 != level_q) begin
            if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync_q2;
                count   <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end else begin
            count <= '0;
        end
    end

    // Registered rise detector on the debounced level
    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev <= 1'b0;
            pulse      <= 1'b0;
        end else begin
            level_prev <= level_q;
            pulse      <= level_q & ~level_prev;
        end
    end

    assign level = level_q;

`endif

endmodule

// File: rtl/player_input_ctrl.sv
// Player-input producer: debounces the five board buttons into pulses and
// offers a validated card choice (from the switches) over valid/ready.
// Optional macro PLAYER_INPUT_DEBOUNCE_BYPASS_EN bypasses button debouncing.
module player_input_ctrl
    import player_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_CARDS       = NUM_CARDS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           btn_raw,
    input  logic [NUM_CARDS-1:0] sw_raw,
    input  logic [NUM_CARDS-1:0] avail_mask,
    output logic [4:0]           btn_pulse,
    output logic [4:0]           btn_level,
    output logic                 sel_valid,
    input  logic                 sel_ready,
    output logic [3:0]           sel_index,
    output logic [NUM_CARDS-1:0] sel_onehot,
    output logic                 sel_error
);

    sel_state_t           state;
    logic [NUM_CARDS-1:0] sw_q1;
    logic [NUM_CARDS-1:0] sw_q2;
    logic [NUM_CARDS-1:0] snapshot;
    logic [3:0]           snap_index;
    logic                 snap_single;
    logic                 snap_legal;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .pulse(btn_pulse[i])
        );
    end

    // Two-stage synchronizer for the card switches
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q1 <= '0;
            sw_q2 <= '0;
        end else begin
            sw_q1 <= sw_raw;
            sw_q2 <= sw_q1;
        end
    end

    // Binary position of the (highest) set snapshot bit; only meaningful when exactly one is set
    always_comb begin
        snap_index = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (snapshot[i]) begin
                snap_index = 4'(i);
            end
        end
    end

    assign snap_single = (snapshot != '0) &&
                         ((snapshot & (snapshot - NUM_CARDS'(1))) == '0);
    assign snap_legal  = snap_single && ((snapshot & avail_mask) != '0);

    // Selection FSM: snapshot on confirm, validate for one cycle, then hold the offer until taken or cancelled
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            snapshot   <= '0;
            sel_valid  <= 1'b0;
            sel_index  <= '0;
            sel_onehot <= '0;
            sel_error  <= 1'b0;
        end else begin
            sel_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_pulse[BTN_TOP]) begin
                        snapshot <= sw_q2;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (snap_legal) begin
                        sel_valid  <= 1'b1;
                        sel_index  <= snap_index;
                        sel_onehot <= snapshot;
                        state      <= OFFER;
                    end else begin
                        sel_error <= 1'b1;
                        state     <= IDLE;
                    end
                end
                OFFER: begin
                    if (sel_ready || btn_pulse[BTN_BOTTOM]) begin
                        sel_valid  <= 1'b0;
                        sel_index  <= '0;
                        sel_onehot <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    sel_valid  <= 1'b0;
                    sel_index  <= '0;
                    sel_onehot <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed testbench for player_input_ctrl with DEBOUNCE_CYCLES=4, NUM_CARDS=9.
module tb_player_input_ctrl;

    localparam int DC = 4;
    localparam int NC = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    btn_raw;
    logic [NC-1:0] sw_raw;
    logic [NC-1:0] avail_mask;
    logic [4:0]    btn_pulse;
    logic [4:0]    btn_level;
    logic          sel_valid;
    logic          sel_ready;
    logic [3:0]    sel_index;
    logic [NC-1:0] sel_onehot;
    logic          sel_error;

    int passes = 0;
    int total  = 0;
    int xfers  = 0;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .NUM_CARDS      (NC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .avail_mask(avail_mask),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel_index (sel_index),
        .sel_onehot(sel_onehot),
        .sel_error (sel_error)
    );

    always #5 clk = ~clk;

    // Count completed handshakes as seen by the consumer
    always @(posedge clk) begin
        if (!reset && sel_valid && sel_ready) xfers = xfers + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_btn(input int idx);
        int k;
        k = 0;
        btn_raw[idx] = 1'b1;
        while (btn_pulse[idx] !== 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        total++;
        if (btn_pulse[idx] !== 1'b1) $display("[TB] FAIL press_timeout btn%0d: pulse=%b required 1", idx, btn_pulse[idx]);
        else passes++;
    endtask

    task automatic make_offer(input logic [NC-1:0] sw, input logic [NC-1:0] av);
        sw_raw     = sw;
        avail_mask = av;
        step(2);
        press_btn(1);
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_raw = '0; sw_raw = '0; avail_mask = '0; sel_ready = 1'b0;
        step(3);
        total++;
        if ({btn_pulse, btn_level, sel_valid, sel_index, sel_onehot, sel_error} !== '0)
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {btn_pulse, btn_level, sel_valid, sel_index, sel_onehot, sel_error});
        else passes++;
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_clean_press();
        btn_raw[0] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step(1);
            total++;
            if (btn_pulse[0] !== (c == 7)) $display("[TB] FAIL clean_pulse c%0d: got %b required %b", c, btn_pulse[0], (c == 7));
            else passes++;
        end
        total++;
        if (btn_level[0] !== 1'b1) $display("[TB] FAIL clean_level: got %b required 1", btn_level[0]);
        else passes++;
        btn_raw[0] = 1'b0;
        step(10);
    endtask

    task automatic test_glitch();
        btn_raw[3] = 1'b1;
        step(3);
        btn_raw[3] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            total++;
            if (btn_pulse[3] !== 1'b0 || btn_level[3] !== 1'b0)
                $display("[TB] FAIL glitch c%0d: pulse=%b level=%b required 0 0", c, btn_pulse[3], btn_level[3]);
            else passes++;
        end
    endtask

    task automatic test_offer();
        int x0;
        x0 = xfers;
        make_offer(9'b000010000, 9'h1FF);
        total++;
        if ({sel_valid, sel_index, sel_onehot} !== {1'b1, 4'd4, 9'h010})
            $display("[TB] FAIL offer_load: got %b/%0d/%h required 1/4/010", sel_valid, sel_index, sel_onehot);
        else passes++;
        sw_raw = 9'h001;
        btn_raw[1] = 1'b0;
        step(10);
        total++;
        if ({sel_valid, sel_index, sel_onehot} !== {1'b1, 4'd4, 9'h010})
            $display("[TB] FAIL offer_stable: got %b/%0d/%h required 1/4/010", sel_valid, sel_index, sel_onehot);
        else passes++;
        sel_ready = 1'b1;
        step(1);
        sel_ready = 1'b0;
        total++;
        if ({sel_valid, sel_index, sel_onehot} !== '0 || xfers !== x0 + 1)
            $display("[TB] FAIL offer_transfer: valid=%b idx=%0d oh=%h xfers=%0d required 0/0/0 xfers=%0d",
                     sel_valid, sel_index, sel_onehot, xfers, x0 + 1);
        else passes++;
        sel_ready = 1'b1;
        step(2);
        sel_ready = 1'b0;
        total++;
        if (sel_valid !== 1'b0 || xfers !== x0 + 1)
            $display("[TB] FAIL ready_idle: valid=%b xfers=%0d required 0 xfers=%0d", sel_valid, xfers, x0 + 1);
        else passes++;
    endtask

    task automatic test_illegal(input logic [NC-1:0] sw, input logic [NC-1:0] av, input int id);
        sw_raw     = sw;
        avail_mask = av;
        step(2);
        press_btn(1);
        step(1);
        total++;
        if (sel_error !== 1'b0) $display("[TB] FAIL illegal%0d_early: error=%b required 0", id, sel_error);
        else passes++;
        step(1);
        total++;
        if (sel_error !== 1'b1 || sel_valid !== 1'b0)
            $display("[TB] FAIL illegal%0d_error: error=%b valid=%b required 1 0", id, sel_error, sel_valid);
        else passes++;
        step(1);
        total++;
        if (sel_error !== 1'b0 || sel_valid !== 1'b0)
            $display("[TB] FAIL illegal%0d_after: error=%b valid=%b required 0 0", id, sel_error, sel_valid);
        else passes++;
        btn_raw[1] = 1'b0;
        step(10);
    endtask

    task automatic test_cancel();
        int x0;
        int k;
        x0 = xfers;
        make_offer(9'b000000010, 9'h1FF);
        btn_raw[1] = 1'b0;
        step(10);
        total++;
        if ({sel_valid, sel_index} !== {1'b1, 4'd1})
            $display("[TB] FAIL cancel_offer: got %b/%0d required 1/1", sel_valid, sel_index);
        else passes++;
        press_btn(2);
        total++;
        if (sel_valid !== 1'b1) $display("[TB] FAIL cancel_before: valid=%b required 1", sel_valid);
        else passes++;
        step(1);
        total++;
        if ({sel_valid, sel_onehot} !== '0 || xfers !== x0)
            $display("[TB] FAIL cancel_drop: valid=%b oh=%h xfers=%0d required 0 0 xfers=%0d", sel_valid, sel_onehot, xfers, x0);
        else passes++;
        btn_raw[2] = 1'b0;
        step(10);

        make_offer(9'b001000000, 9'h1FF);
        btn_raw[1] = 1'b0;
        step(10);
        btn_raw[2] = 1'b1;
        k = 0;
        while (btn_pulse[2] !== 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        sel_ready = 1'b1;
        step(1);
        sel_ready = 1'b0;
        total++;
        if (sel_valid !== 1'b0 || xfers !== x0 + 1)
            $display("[TB] FAIL cancel_ready_wins: valid=%b xfers=%0d required 0 xfers=%0d", sel_valid, xfers, x0 + 1);
        else passes++;
        btn_raw[2] = 1'b0;
        step(10);
    endtask

    task automatic test_reset_mid_offer();
        int x0;
        x0 = xfers;
        make_offer(9'b100000000, 9'h1FF);
        total++;
        if ({sel_valid, sel_index} !== {1'b1, 4'd8})
            $display("[TB] FAIL rst_offer: got %b/%0d required 1/8", sel_valid, sel_index);
        else passes++;
        sw_raw = '0;
        reset  = 1'b1;
        step(1);
        total++;
        if ({btn_pulse, btn_level, sel_valid, sel_index, sel_onehot, sel_error} !== '0 || xfers !== x0)
            $display("[TB] FAIL rst_outputs: got %h xfers=%0d required 0 xfers=%0d",
                     {btn_pulse, btn_level, sel_valid, sel_index, sel_onehot, sel_error}, xfers, x0);
        else passes++;
        step(2);
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step(1);
            total++;
            if (btn_pulse[1] !== (c == 7)) $display("[TB] FAIL rst_held_pulse c%0d: got %b required %b", c, btn_pulse[1], (c == 7));
            else passes++;
        end
        btn_raw[1] = 1'b0;
        step(10);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_offer();
        test_illegal(9'b000000101, 9'h1FF, 1);
        test_illegal(9'b000000000, 9'h1FF, 2);
        test_illegal(9'b000001000, 9'h1F7, 3);
        test_cancel();
        test_reset_mid_offer();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
